alu_exec: RTL and testbench

Parametrised execute-stage ALU that succeeds the purely combinational ALU control decode. It accepts the same `alu_op`/`funct3`/`funct7` encoding plus operands over a valid/ready handshake, decodes the full RV32I integer operation set plus `MUL`, and returns a registered result. Single-cycle operations complete in one cycle; `MUL` runs on an iterative shift-add engine. It sits between the register-read and memory/writeback stages.

---
 rtl/alu_exec_if.sv | 39 +++
 rtl/alu_exec.sv | 268 ++++++++++++++++++++++++++
 tb/tb_alu_exec.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_if
//  Description : Request/response bundle for the execute-stage ALU.
//                Request side : in_valid/in_ready handshake carrying
//                               alu_op, funct3, funct7, op_a, op_b.
//                Response side: out_valid/out_ready handshake carrying
//                               result, zero, illegal.
//                master = register-read stage + writeback consumer,
//                slave  = alu_exec.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_op, funct3, funct7, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec
//  Description : Execute-stage integer ALU with valid/ready handshakes.
//                Decodes the RV32I integer op set (plus MUL) from
//                alu_op/funct3/funct7, completes single-cycle ops and
//                illegal encodings in one cycle and runs MUL on an
//                iterative shift-add engine taking XLEN cycles.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - alu_exec_if.slave (request + registered response)
//  Parameters  : XLEN       - operand/result width (power of two, >= 8)
//                MUL_ENABLE - 1 = MUL supported, 0 = MUL decodes illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec #(
    parameter int XLEN       = 32,
    parameter int MUL_ENABLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_exec_if.slave     bus
);

    localparam int c_SHW = $clog2(XLEN);
    localparam int c_CW  = c_SHW + 1;

    // FSM encoding
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MUL  = 1'b1;

    // Internal operation codes produced by the decoder
    localparam logic [3:0] c_FN_ADD  = 4'd0;
    localparam logic [3:0] c_FN_SUB  = 4'd1;
    localparam logic [3:0] c_FN_SLL  = 4'd2;
    localparam logic [3:0] c_FN_SLT  = 4'd3;
    localparam logic [3:0] c_FN_SLTU = 4'd4;
    localparam logic [3:0] c_FN_XOR  = 4'd5;
    localparam logic [3:0] c_FN_SRL  = 4'd6;
    localparam logic [3:0] c_FN_SRA  = 4'd7;
    localparam logic [3:0] c_FN_OR   = 4'd8;
    localparam logic [3:0] c_FN_AND  = 4'd9;
    localparam logic [3:0] c_FN_MUL  = 4'd10;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;

    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;
    logic            r_illegal;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [3:0]       w_fn;
    logic             w_ill;
    logic [c_SHW-1:0] w_shamt;
    logic [XLEN-1:0]  w_sc_res;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_start_mul;
    logic             w_load_sc;
    logic             w_mul_last;
    logic [XLEN-1:0]  w_acc_step;

    // ------------------------------------------------------------------
    // Decode alu_op/funct3/funct7 into an operation code
    // ------------------------------------------------------------------
    always_comb begin
        w_fn  = c_FN_ADD;
        w_ill = 1'b0;
        case (bus.alu_op)
            2'b00: w_fn = c_FN_ADD;
            2'b01: w_fn = c_FN_SUB;
            2'b10: begin
                case (bus.funct7)
                    7'b0000000: begin
                        case (bus.funct3)
                            3'b000:  w_fn = c_FN_ADD;
                            3'b001:  w_fn = c_FN_SLL;
                            3'b010:  w_fn = c_FN_SLT;
                            3'b011:  w_fn = c_FN_SLTU;
                            3'b100:  w_fn = c_FN_XOR;
                            3'b101:  w_fn = c_FN_SRL;
                            3'b110:  w_fn = c_FN_OR;
                            default: w_fn = c_FN_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (bus.funct3 == 3'b000) begin
                            w_fn = c_FN_SUB;
                        end else if (bus.funct3 == 3'b101) begin
                            w_fn = c_FN_SRA;
                        end else begin
                            w_ill = 1'b1;
                        end
                    end
                    7'b0000001: begin
                        if ((bus.funct3 == 3'b000) && (MUL_ENABLE != 0)) begin
                            w_fn = c_FN_MUL;
                        end else begin
                            w_ill = 1'b1;
                        end
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            default: begin
                // I-type: funct7 is immediate bits except for the shifts,
                // where it selects logical vs arithmetic.
                case (bus.funct3)
                    3'b000: w_fn = c_FN_ADD;
                    3'b001: begin
                        if (bus.funct7 == 7'b0000000) begin
                            w_fn = c_FN_SLL;
                        end else begin
                            w_ill = 1'b1;
                        end
                    end
                    3'b010: w_fn = c_FN_SLT;
                    3'b011: w_fn = c_FN_SLTU;
                    3'b100: w_fn = c_FN_XOR;
                    3'b101: begin
                        if (bus.funct7 == 7'b0000000) begin
                            w_fn = c_FN_SRL;
                        end else if (bus.funct7 == 7'b0100000) begin
                            w_fn = c_FN_SRA;
                        end else begin
                            w_ill = 1'b1;
                        end
                    end
                    3'b110:  w_fn = c_FN_OR;
                    default: w_fn = c_FN_AND;
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign w_shamt = bus.op_b[c_SHW-1:0];

    always_comb begin
        w_sc_res = '0;
        if (!w_ill) begin
            case (w_fn)
                c_FN_ADD:  w_sc_res = bus.op_a + bus.op_b;
                c_FN_SUB:  w_sc_res = bus.op_a - bus.op_b;
                c_FN_SLL:  w_sc_res = bus.op_a << w_shamt;
                c_FN_SLT:  w_sc_res = {{(XLEN-1){1'b0}},
                                       ($signed(bus.op_a) < $signed(bus.op_b))};
                c_FN_SLTU: w_sc_res = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
                c_FN_XOR:  w_sc_res = bus.op_a ^ bus.op_b;
                c_FN_SRL:  w_sc_res = bus.op_a >> w_shamt;
                c_FN_SRA:  w_sc_res = $unsigned($signed(bus.op_a) >>> w_shamt);
                c_FN_OR:   w_sc_res = bus.op_a | bus.op_b;
                c_FN_AND:  w_sc_res = bus.op_a & bus.op_b;
                default:   w_sc_res = '0;   // MUL goes through the engine
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    assign w_in_ready  = (r_state == c_ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_start_mul = w_accept && !w_ill && (w_fn == c_FN_MUL);
    assign w_load_sc   = w_accept && !w_start_mul;
    assign w_mul_last  = (r_state == c_ST_MUL) && (r_cnt == c_CW'(1));

    // One shift-add step: the final step's sum is what gets written out,
    // so the result register is loaded from this and not from r_acc.
    assign w_acc_step  = r_acc + ({XLEN{r_mplier[0]}} & r_mcand);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_mul) begin
                    w_state_nxt = c_ST_MUL;
                end
            end
            c_ST_MUL: begin
                if (w_mul_last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add multiplier engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (w_start_mul) begin
            r_cnt    <= c_CW'(XLEN);
            r_mcand  <= bus.op_a;
            r_mplier <= bus.op_b;
            r_acc    <= '0;
        end else if (r_state == c_ST_MUL) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - c_CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output register: held while the consumer stalls. A MUL can only
    // have been started with the output slot empty or draining, so its
    // completion never collides with a pending result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_load_sc) begin
            r_out_valid <= 1'b1;
            r_result    <= w_sc_res;
            r_zero      <= (w_sc_res == '0);
            r_illegal   <= w_ill;
        end else if (w_mul_last) begin
            r_out_valid <= 1'b1;
            r_result    <= w_acc_step;
            r_zero      <= (w_acc_step == '0);
            r_illegal   <= 1'b0;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec
//  Description : Scoreboard bench for alu_exec. Directed cases for the
//                documented corner behaviour, then randomized traffic with
//                random consumer stalls checked against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_exec_if #(.XLEN(XLEN)) bus ();
    alu_exec_if #(.XLEN(XLEN)) bus_nm ();

    alu_exec #(.XLEN(XLEN), .MUL_ENABLE(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    alu_exec #(.XLEN(XLEN), .MUL_ENABLE(0)) u_dut_nm (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nm)
    );

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_err    = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    initial forever #5 clk = ~clk;

    // Consumer ready, updated #2 after each rising edge
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Reference model: straight from the operation table
    // ------------------------------------------------------------------
    function automatic logic [31:0] base_op(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (f3)
            3'd0:    return a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] sra_ref(input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        // negative: shift the complement logically, complement back
        return a[31] ? ~((~a) >> sh) : (a >> sh);
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] a,
                                   input logic [31:0] b, input bit mul_en);
        exp_t        e;
        logic [31:0] r;
        logic [63:0] p;
        bit          ill;
        r   = 32'd0;
        ill = 1'b0;
        if (op == 2'b00) begin
            r = a + b;
        end else if (op == 2'b01) begin
            r = a - b;
        end else if (op == 2'b10) begin
            if (f7 == 7'h00)                                 r = base_op(f3, a, b);
            else if (f7 == 7'h20 && f3 == 3'd0)              r = a - b;
            else if (f7 == 7'h20 && f3 == 3'd5)              r = sra_ref(a, b);
            else if (f7 == 7'h01 && f3 == 3'd0 && mul_en) begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
            end else                                         ill = 1'b1;
        end else begin
            if (f3 == 3'd1 && f7 != 7'h00)                   ill = 1'b1;
            else if (f3 == 3'd5 && f7 == 7'h20)              r = sra_ref(a, b);
            else if (f3 == 3'd5 && f7 != 7'h00)              ill = 1'b1;
            else                                             r = base_op(f3, a, b);
        end
        e.res  = ill ? 32'd0 : r;
        e.zero = (e.res == 32'd0);
        e.ill  = ill;
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b, output int waited);
        bit ok;
        ok     = 1'b0;
        waited = 0;
        bus.alu_op   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", waited);
                    break;
                end
                @(posedge clk);
                #1;
            end
        end
        if (ok) sb.push_back(model(op, f3, f7, a, b, 1'b1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Single-cycle op with its one-cycle latency checked against constants
    task automatic direct(input string name, input logic [1:0] op,
                          input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill);
        int w;
        send(op, f3, f7, a, b, w);
        @(negedge clk);
        chk1({name, "_valid"},   bus.out_valid, 1'b1);
        chk ({name, "_result"},  bus.result,    exp_res);
        chk1({name, "_zero"},    bus.zero,      exp_res == 32'd0);
        chk1({name, "_illegal"}, bus.illegal,   exp_ill);
        @(posedge clk);
        #1;
    endtask

    task automatic nm_op(input string name, input logic [1:0] op,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ill);
        bus_nm.alu_op   = op;
        bus_nm.funct3   = f3;
        bus_nm.funct7   = f7;
        bus_nm.op_a     = a;
        bus_nm.op_b     = b;
        bus_nm.in_valid = 1'b1;
        @(negedge clk);
        chk1({name, "_in_ready"}, bus_nm.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus_nm.in_valid = 1'b0;
        @(negedge clk);
        chk1({name, "_valid"},   bus_nm.out_valid, 1'b1);
        chk ({name, "_result"},  bus_nm.result,    exp_res);
        chk1({name, "_zero"},    bus_nm.zero,      exp_res == 32'd0);
        chk1({name, "_illegal"}, bus_nm.illegal,   exp_ill);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 400) begin
            @(posedge clk);
            c++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 63));
            default: return $urandom();
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Main sequence with the scoreboard monitor forked alongside
    // ------------------------------------------------------------------
    initial begin
        int          w;
        int          cyc;
        bit          low_ok;
        logic [1:0]  r_op;
        logic [2:0]  r_f3;
        logic [6:0]  r_f7;

        bus.in_valid    = 1'b0;
        bus.alu_op      = 2'b00;
        bus.funct3      = 3'd0;
        bus.funct7      = 7'd0;
        bus.op_a        = 32'd0;
        bus.op_b        = 32'd0;
        bus_nm.in_valid  = 1'b0;
        bus_nm.alu_op    = 2'b00;
        bus_nm.funct3    = 3'd0;
        bus_nm.funct7    = 7'd0;
        bus_nm.op_a      = 32'd0;
        bus_nm.op_b      = 32'd0;
        bus_nm.out_ready = 1'b1;

        fork
            begin : mon
                bit          hold;
                logic [31:0] h_res;
                logic        h_zero;
                logic        h_ill;
                exp_t        e;
                hold = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        hold = 1'b0;
                    end else begin
                        if (hold) begin
                            chk1("hold_valid",   bus.out_valid, 1'b1);
                            chk ("hold_result",  bus.result,    h_res);
                            chk1("hold_zero",    bus.zero,      h_zero);
                            chk1("hold_illegal", bus.illegal,   h_ill);
                        end
                        if (bus.out_valid && bus.out_ready) begin
                            if (sb.size() == 0) begin
                                n_chk++;
                                n_err++;
                                $display("FAIL sb_unexpected: got result 0x%08h, expected no output", bus.result);
                            end else begin
                                e = sb.pop_front();
                                chk ("sb_result",  bus.result,  e.res);
                                chk1("sb_zero",    bus.zero,    e.zero);
                                chk1("sb_illegal", bus.illegal, e.ill);
                            end
                        end
                        hold   = bus.out_valid && !bus.out_ready;
                        h_res  = bus.result;
                        h_zero = bus.zero;
                        h_ill  = bus.illegal;
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk ("rst_result",    bus.result,    32'd0);
        chk1("rst_zero",      bus.zero,      1'b0);
        chk1("rst_illegal",   bus.illegal,   1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed single-cycle ops
        direct("add",        2'b10, 3'd0, 7'h00, 32'd5, 32'd7, 32'd12, 1'b0);
        direct("sub_zero",   2'b10, 3'd0, 7'h20, 32'd9, 32'd9, 32'd0,  1'b0);
        direct("srai",       2'b11, 3'd5, 7'h20, 32'h8000_0000, 32'h0000_0404,
               32'hF800_0000, 1'b0);
        direct("slt",        2'b10, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        direct("sltu",       2'b10, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
        direct("ls_add",     2'b00, 3'd7, 7'h7F, 32'd10, 32'd20, 32'd30, 1'b0);
        direct("br_sub",     2'b01, 3'd5, 7'h20, 32'd10, 32'd20, 32'hFFFF_FFF6, 1'b0);
        direct("ill_decode", 2'b10, 3'd7, 7'h20, 32'd3, 32'd4, 32'd0, 1'b1);
        direct("ill_slli",   2'b11, 3'd1, 7'h01, 32'd3, 32'd4, 32'd0, 1'b1);
        direct("ill_f7",     2'b10, 3'd0, 7'h10, 32'd3, 32'd4, 32'd0, 1'b1);

        // MUL latency, result and in_ready behaviour
        send(2'b10, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'd3, w);
        cyc    = 0;
        low_ok = 1'b1;
        while (cyc < 100) begin
            @(negedge clk);
            if (bus.out_valid) break;
            if (bus.in_ready) low_ok = 1'b0;
            cyc++;
        end
        chk ("mul_latency",      32'(cyc), 32'd32);
        chk1("mul_in_ready_low", low_ok,   1'b1);
        chk ("mul_result",       bus.result, 32'hFFFF_FFFD);
        @(posedge clk);
        #1;

        // MUL disabled instance
        nm_op("nm_mul", 2'b10, 3'd0, 7'h01, 32'd7, 32'd6, 32'd0,  1'b1);
        nm_op("nm_add", 2'b10, 3'd0, 7'h00, 32'd7, 32'd6, 32'd13, 1'b0);

        // Back-pressure
        rdy_mode = 2;
        send(2'b00, 3'd0, 7'h00, 32'd20, 32'd22, w);
        bus.alu_op   = 2'b01;
        bus.op_a     = 32'd100;
        bus.op_b     = 32'd1;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk1("bp_in_ready_low", bus.in_ready,  1'b0);
            chk1("bp_valid",        bus.out_valid, 1'b1);
            chk ("bp_result",       bus.result,    32'd42);
            @(posedge clk);
            #1;
        end
        rdy_mode = 0;
        send(2'b01, 3'd0, 7'h00, 32'd100, 32'd1, w);
        chk("bp_accept_on_release", 32'(w), 32'd0);
        @(negedge clk);
        chk1("bp_next_valid",  bus.out_valid, 1'b1);
        chk ("bp_next_result", bus.result,    32'd99);
        @(posedge clk);
        #1;

        // Reset during MUL cycle 10
        direct("pre_rst_add", 2'b00, 3'd0, 7'h00, 32'd3, 32'd4, 32'd7, 1'b0);
        send(2'b10, 3'd0, 7'h01, 32'h0000_1234, 32'h0000_5678, w);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk1("midrst_valid",   bus.out_valid, 1'b0);
        chk ("midrst_result",  bus.result,    32'd0);
        chk1("midrst_zero",    bus.zero,      1'b0);
        chk1("midrst_illegal", bus.illegal,   1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        direct("post_rst_add", 2'b00, 3'd0, 7'h00, 32'd1, 32'd1, 32'd2, 1'b0);

        // Randomized traffic with random consumer stalls
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0, 1, 2, 3: r_f7 = 7'h00;
                4, 5:       r_f7 = 7'h20;
                6, 7:       r_f7 = 7'h01;
                default:    r_f7 = 7'($urandom_range(0, 127));
            endcase
            send(r_op, r_f3, r_f7, rnd_operand(), rnd_operand(), w);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
